mips_decode_exec: RTL and testbench
===================================

// Module: mips_decode_exec
// PURPOSE
// - Single-cycle-latency decode + execute stage of the MIPS-subset core: splits a 32-bit instruction into
//   fields and controls, selects ALU operand B, computes result/zero/overflow, registers all outputs.
// - Sits between instruction fetch (PC/jump logic consumes branch_taken/jump) and the register-file/memory write-back.
// PARAMETERS
// - none (32-bit datapath, 5-bit register indices fixed)
// PORTS
// - clk           in   1   rising-edge clock (only clock)
// - rst           in   1   asynchronous, active-high reset
// - in_valid      in   1   instr/rs_data/rt_data valid this cycle
// - instr         in   32  instruction word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
// - rs_data       in   32  register-file value of rs (combinational read)
// - rt_data       in   32  register-file value of rt
// - rs_addr       out  5   instr[25:21], combinational
// - rt_addr       out  5   instr[20:16], combinational
// - out_valid     out  1   registered in_valid
// - alu_result    out  32  ALU output
// - store_data    out  32  rt_data for SW
// - wr_reg        out  5   rd (R-type) else rt
// - imm_sext      out  32  sign-extended instr[15:0] (branch offset, word units)
// - targ_addr     out  26  instr[25:0]
// - regwrite, memtoreg, memwrite, branch, jump  out 1 each  write-back/PC controls
// - branch_taken  out  1   branch & zero
// - zero          out  1   alu_result == 0
// - overflow      out  1   signed overflow on ADD/ADDI/SUB only; informational, no trap
// - illegal       out  1   unknown opcode/funct; all write/branch/jump controls forced 0
// BEHAVIOUR
// - Reset: all registered outputs 0 immediately (async); rs_addr/rt_addr stay combinational.
// - Latency 1: outputs update on posedge clk after in_valid; in_valid=0 -> register NOP (controls 0, out_valid 0).
// - R-type op 0x00, dest rd: funct 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT,
//   2B SLTU, 00 SLL, 02 SRL, 03 SRA (shamt), 04 SLLV, 06 SRLV (rs_data[4:0] shifts rt_data).
// - I-type, dest rt: 08 ADDI, 09 ADDIU, 0A SLTI, 0B SLTIU (sign-ext imm); 0C ANDI, 0D ORI, 0E XORI (zero-ext imm);
//   0F LUI = {imm,16'h0}; 23 LW (rs+sext, memtoreg=1); 2B SW (rs+sext, memwrite=1, regwrite=0).
// - 04 BEQ: ALU SUB rs-rt, branch=1, regwrite=0; 02 J: jump=1, all writes 0.
// - Writes to register 0 permitted at this stage (regfile ignores); 0x00000020 (ADD r0,r0,r0) is canonical NOP.
// - SLT signed compare, SLTU/SLTIU unsigned; result 32'd1/32'd0. Shifts use amount mod 32.
// - overflow: ADD/ADDI/SUB when operand signs imply sign flip; ADDU/ADDIU/SUBU never set it.
// - zero reflects every op's result (not only BEQ); branch_taken only when branch=1.
// - Reset asserted mid-stream: outputs clear at once; first valid output is the first in_valid after deassert.
// CONFIGURATION
// - SHIFT_UNIT_EN: defined -> SLL/SRL/SRA/SLLV/SRLV/LUI implemented as above.
//   Not defined -> those encodings decode as illegal=1 with all controls 0 and alu_result 0.
// TESTING
// - ADD r2,r2,r1 0x00411020, rs=0, rt=10 -> alu_result 10, wr_reg 2, regwrite 1, zero 0, 1 cycle later.
// - ADDI r1,r1,-1 0x2021FFFF, rs=10 -> 9, wr_reg 1; rs=1 -> 0, zero 1.
// - BEQ r1,r0,+3 0x10200003, rs=rt=0 -> branch_taken 1, imm_sext 3; rs=5 -> branch_taken 0; regwrite 0.
// - J 1 0x08000001 -> jump 1, targ_addr 1, regwrite/memwrite 0; SW 0xAC420000 rs=5, rt=55 -> alu_result 5,
//   store_data 55, memwrite 1; LW 0x8C430001 rs=2 -> 3, memtoreg 1.
// - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow 1; ADDU same -> overflow 0; funct 3F -> illegal 1.
// - Assert rst mid-stream -> all outputs 0 without clock edge; SHIFT_UNIT_EN off: SLL 0x00011080 -> illegal 1.

Source files
------------

// File: rtl/mips_decode_exec.sv
// Decode + execute stage of the MIPS-subset core: field split, control decode, ALU, one register stage.
// Optional feature macro: SHIFT_UNIT_EN (SLL/SRL/SRA/SLLV/SRLV/LUI); undefined -> those decode as illegal.
module mips_decode_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic        out_valid,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic [4:0]  wr_reg,
   output logic [31:0] imm_sext,
   output logic [25:0] targ_addr,
   output logic        regwrite,
   output logic        memtoreg,
   output logic        memwrite,
   output logic        branch,
   output logic        jump,
   output logic        branch_taken,
   output logic        zero,
   output logic        overflow,
   output logic        illegal
);

   typedef enum logic [3:0] {
      ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   logic [5:0]  op, funct;
   logic [31:0] sext, zext;
   alu_op_t     alu_op;
   logic        use_imm, imm_zext, dst_rd, shift_var, ovf_chk;
   logic        rw_c, mr_c, mw_c, br_c, jp_c, ill_c;

   assign op      = instr[31:26];
   assign funct   = instr[5:0];
   assign sext    = {{16{instr[15]}}, instr[15:0]};
   assign zext    = {16'h0000, instr[15:0]};
   assign rs_addr = instr[25:21];
   assign rt_addr = instr[20:16];

   always_comb begin
      alu_op    = ALU_NONE;
      use_imm   = 1'b0;
      imm_zext  = 1'b0;
      dst_rd    = 1'b0;
      shift_var = 1'b0;
      ovf_chk   = 1'b0;
      rw_c      = 1'b0;
      mr_c      = 1'b0;
      mw_c      = 1'b0;
      br_c      = 1'b0;
      jp_c      = 1'b0;
      ill_c     = 1'b0;
      case (op)
         6'h00: begin
            dst_rd = 1'b1;
            rw_c   = 1'b1;
            case (funct)
               6'h20: begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
               6'h21: alu_op = ALU_ADD;
               6'h22: begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
               6'h23: alu_op = ALU_SUB;
               6'h24: alu_op = ALU_AND;
               6'h25: alu_op = ALU_OR;
               6'h26: alu_op = ALU_XOR;
               6'h27: alu_op = ALU_NOR;
               6'h2A: alu_op = ALU_SLT;
               6'h2B: alu_op = ALU_SLTU;
`ifdef SHIFT_UNIT_EN
               6'h00: alu_op = ALU_SLL;
               6'h02: alu_op = ALU_SRL;
               6'h03: alu_op = ALU_SRA;
               6'h04: begin alu_op = ALU_SLL; shift_var = 1'b1; end
               6'h06: begin alu_op = ALU_SRL; shift_var = 1'b1; end
`endif
               default: ill_c = 1'b1;
            endcase
         end
         6'h08: begin alu_op = ALU_ADD;  use_imm = 1'b1; rw_c = 1'b1; ovf_chk = 1'b1; end
         6'h09: begin alu_op = ALU_ADD;  use_imm = 1'b1; rw_c = 1'b1; end
         6'h0A: begin alu_op = ALU_SLT;  use_imm = 1'b1; rw_c = 1'b1; end
         6'h0B: begin alu_op = ALU_SLTU; use_imm = 1'b1; rw_c = 1'b1; end
         6'h0C: begin alu_op = ALU_AND;  use_imm = 1'b1; imm_zext = 1'b1; rw_c = 1'b1; end
         6'h0D: begin alu_op = ALU_OR;   use_imm = 1'b1; imm_zext = 1'b1; rw_c = 1'b1; end
         6'h0E: begin alu_op = ALU_XOR;  use_imm = 1'b1; imm_zext = 1'b1; rw_c = 1'b1; end
`ifdef SHIFT_UNIT_EN
         6'h0F: begin alu_op = ALU_LUI;  use_imm = 1'b1; rw_c = 1'b1; end
`endif
         6'h23: begin alu_op = ALU_ADD;  use_imm = 1'b1; rw_c = 1'b1; mr_c = 1'b1; end
         6'h2B: begin alu_op = ALU_ADD;  use_imm = 1'b1; mw_c = 1'b1; end
         6'h04: begin alu_op = ALU_SUB;  br_c = 1'b1; end
         6'h02: jp_c = 1'b1;
         default: ill_c = 1'b1;
      endcase
      // Illegal encodings must not disturb write-back or PC flow.
      if (ill_c) begin
         alu_op  = ALU_NONE;
         ovf_chk = 1'b0;
         rw_c    = 1'b0;
         mr_c    = 1'b0;
         mw_c    = 1'b0;
         br_c    = 1'b0;
         jp_c    = 1'b0;
      end
   end

   logic [31:0] b_op, sum, diff, alu_res;
   logic [4:0]  shamt;
   logic        ovf_c;

   always_comb begin
      b_op  = use_imm ? (imm_zext ? zext : sext) : rt_data;
      shamt = shift_var ? rs_data[4:0] : instr[10:6];
      sum   = rs_data + b_op;
      diff  = rs_data - b_op;
      case (alu_op)
         ALU_ADD:  alu_res = sum;
         ALU_SUB:  alu_res = diff;
         ALU_AND:  alu_res = rs_data & b_op;
         ALU_OR:   alu_res = rs_data | b_op;
         ALU_XOR:  alu_res = rs_data ^ b_op;
         ALU_NOR:  alu_res = ~(rs_data | b_op);
         ALU_SLT:  alu_res = {31'b0, $signed(rs_data) < $signed(b_op)};
         ALU_SLTU: alu_res = {31'b0, rs_data < b_op};
         ALU_SLL:  alu_res = b_op << shamt;
         ALU_SRL:  alu_res = b_op >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(b_op) >>> shamt);
         ALU_LUI:  alu_res = {instr[15:0], 16'h0000};
         default:  alu_res = '0;
      endcase
      if (alu_op == ALU_SUB)
         ovf_c = ovf_chk & (rs_data[31] != b_op[31]) & (diff[31] != rs_data[31]);
      else
         ovf_c = ovf_chk & (rs_data[31] == b_op[31]) & (sum[31] != rs_data[31]);
   end

   logic        out_valid_d, out_valid_q;
   logic [31:0] alu_result_d, alu_result_q, store_data_d, store_data_q;
   logic [31:0] imm_sext_d, imm_sext_q;
   logic [25:0] targ_addr_d, targ_addr_q;
   logic [4:0]  wr_reg_d, wr_reg_q;
   logic [8:0]  ctl_d, ctl_q;

   always_comb begin
      out_valid_d  = 1'b0;
      alu_result_d = '0;
      store_data_d = '0;
      imm_sext_d   = '0;
      targ_addr_d  = '0;
      wr_reg_d     = '0;
      ctl_d        = '0;
      if (in_valid) begin
         out_valid_d  = 1'b1;
         alu_result_d = alu_res;
         store_data_d = rt_data;
         imm_sext_d   = sext;
         targ_addr_d  = instr[25:0];
         wr_reg_d     = dst_rd ? instr[15:11] : instr[20:16];
         ctl_d        = {rw_c, mr_c, mw_c, br_c, jp_c, br_c & (alu_res == '0),
                         alu_res == '0, ovf_c, ill_c};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         alu_result_q <= '0;
         store_data_q <= '0;
         imm_sext_q   <= '0;
         targ_addr_q  <= '0;
         wr_reg_q     <= '0;
         ctl_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         imm_sext_q   <= imm_sext_d;
         targ_addr_q  <= targ_addr_d;
         wr_reg_q     <= wr_reg_d;
         ctl_q        <= ctl_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign alu_result = alu_result_q;
   assign store_data = store_data_q;
   assign imm_sext   = imm_sext_q;
   assign targ_addr  = targ_addr_q;
   assign wr_reg     = wr_reg_q;
   assign {regwrite, memtoreg, memwrite, branch, jump, branch_taken, zero, overflow, illegal} = ctl_q;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Self-checking bench for mips_decode_exec: directed vectors, async reset, randomized stream vs. model.
module tb_mips_decode_exec;

   logic        clk = 1'b0;
   logic        rst, in_valid;
   logic [31:0] instr, rs_data, rt_data;
   logic [4:0]  rs_addr, rt_addr, wr_reg;
   logic        out_valid, regwrite, memtoreg, memwrite, branch, jump;
   logic        branch_taken, zero, overflow, illegal;
   logic [31:0] alu_result, store_data, imm_sext;
   logic [25:0] targ_addr;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mips_decode_exec dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
      .rs_data(rs_data), .rt_data(rt_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .out_valid(out_valid), .alu_result(alu_result), .store_data(store_data),
      .wr_reg(wr_reg), .imm_sext(imm_sext), .targ_addr(targ_addr),
      .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite),
      .branch(branch), .jump(jump), .branch_taken(branch_taken), .zero(zero),
      .overflow(overflow), .illegal(illegal)
   );

   function automatic logic [136:0] observed();
      return {alu_result, store_data, wr_reg, imm_sext, targ_addr, regwrite, memtoreg,
              memwrite, branch, jump, branch_taken, zero, overflow, illegal, out_valid};
   endfunction

   function automatic logic out_of_range(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Reference: what the architecture says the instruction produces, one cycle later.
   function automatic logic [136:0] model(input logic v, input logic [31:0] i, a, b);
      logic [5:0]  op = i[31:26];
      logic [5:0]  fn = i[5:0];
      logic [4:0]  sh = i[10:6];
      logic [31:0] sx = {{16{i[15]}}, i[15:0]};
      logic [31:0] zx = {16'h0000, i[15:0]};
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      sxi = longint'($signed(sx));
      logic [31:0] res = 0;
      logic rw = 0, mr = 0, mw = 0, br = 0, jp = 0, ov = 0, il = 0;
      logic [4:0]  wr = (op == 6'h00) ? i[15:11] : i[20:16];
      if (!v) return '0;
      case (op)
         6'h00: begin
            rw = 1;
            case (fn)
               6'h20: begin res = a + b; ov = out_of_range(sa + sb); end
               6'h21: res = a + b;
               6'h22: begin res = a - b; ov = out_of_range(sa - sb); end
               6'h23: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h27: res = ~(a | b);
               6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
               6'h2B: res = (a < b) ? 32'd1 : 32'd0;
`ifdef SHIFT_UNIT_EN
               6'h00: res = b << sh;
               6'h02: res = b >> sh;
               6'h03: res = 32'(sb >>> sh);
               6'h04: res = b << (a % 32);
               6'h06: res = b >> (a % 32);
`endif
               default: il = 1;
            endcase
         end
         6'h08: begin rw = 1; res = a + sx; ov = out_of_range(sa + sxi); end
         6'h09: begin rw = 1; res = a + sx; end
         6'h0A: begin rw = 1; res = (sa < sxi) ? 32'd1 : 32'd0; end
         6'h0B: begin rw = 1; res = (a < sx) ? 32'd1 : 32'd0; end
         6'h0C: begin rw = 1; res = a & zx; end
         6'h0D: begin rw = 1; res = a | zx; end
         6'h0E: begin rw = 1; res = a ^ zx; end
`ifdef SHIFT_UNIT_EN
         6'h0F: begin rw = 1; res = zx * 65536; end
`endif
         6'h23: begin rw = 1; mr = 1; res = a + sx; end
         6'h2B: begin mw = 1; res = a + sx; end
         6'h04: begin br = 1; res = a - b; end
         6'h02: jp = 1;
         default: il = 1;
      endcase
      if (il) begin rw = 0; mr = 0; mw = 0; br = 0; jp = 0; ov = 0; res = 0; end
      return {res, b, wr, sx, i[25:0], rw, mr, mw, br, jp, br && (res == 0),
              res == 0, ov, il, 1'b1};
   endfunction

   task automatic drive(input logic v, input logic [31:0] i, a, b);
      @(negedge clk);
      in_valid = v;
      instr    = i;
      rs_data  = a;
      rt_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; instr = 32'h00411020; rs_data = 32'd3; rt_data = 32'd4;
      #12;
      vectors++;
      if (observed() !== 137'd0) begin
         $display("FAIL reset_outputs got=%h exp=0", observed()); miscompares++;
      end
      vectors++;
      if ({rs_addr, rt_addr} !== {5'd2, 5'd1}) begin
         $display("FAIL reset_addr got=%h/%h exp=2/1", rs_addr, rt_addr); miscompares++;
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
   endtask

   typedef struct { string name; logic [31:0] i, a, b; } vec_t;

   task automatic test_directed();
      vec_t tbl[$] = '{
         '{"add",     32'h00411020, 32'd0,        32'd10},
         '{"addi",    32'h2021FFFF, 32'd10,       32'd0},
         '{"addi_z",  32'h2021FFFF, 32'd1,        32'd0},
         '{"beq_t",   32'h10200003, 32'd0,        32'd0},
         '{"beq_nt",  32'h10200003, 32'd5,        32'd0},
         '{"j",       32'h08000001, 32'd7,        32'd9},
         '{"sw",      32'hAC420000, 32'd5,        32'd55},
         '{"lw",      32'h8C430001, 32'd2,        32'd0},
         '{"add_ovf", 32'h00411020, 32'h7FFFFFFF, 32'd1},
         '{"addu",    32'h00411021, 32'h7FFFFFFF, 32'd1},
         '{"sub_ovf", 32'h00411022, 32'h80000000, 32'd1},
         '{"illegal", 32'h0041103F, 32'd1,        32'd2},
         '{"sll",     32'h00011080, 32'd0,        32'h0000000F},
         '{"srav_na", 32'h00411007, 32'd1,        32'd2},
         '{"lui",     32'h3C01ABCD, 32'd0,        32'd0},
         '{"slt",     32'h0041102A, 32'hFFFFFFFF, 32'd1},
         '{"sltu",    32'h0041102B, 32'hFFFFFFFF, 32'd1}
      };
      foreach (tbl[k]) begin
         logic [136:0] e;
         drive(1'b1, tbl[k].i, tbl[k].a, tbl[k].b);
         e = model(1'b1, tbl[k].i, tbl[k].a, tbl[k].b);
         vectors++;
         if (observed() !== e) begin
            $display("FAIL %s got=%h exp=%h", tbl[k].name, observed(), e); miscompares++;
         end
         case (tbl[k].name)
            "add": begin
               vectors++;
               if ({alu_result, wr_reg, regwrite, zero} !== {32'd10, 5'd2, 1'b1, 1'b0}) begin
                  $display("FAIL add_fields got=%h/%h/%b/%b exp=a/2/1/0", alu_result, wr_reg, regwrite, zero);
                  miscompares++;
               end
            end
            "beq_t": begin
               vectors++;
               if ({branch_taken, imm_sext, regwrite} !== {1'b1, 32'd3, 1'b0}) begin
                  $display("FAIL beq_fields got=%b/%h/%b exp=1/3/0", branch_taken, imm_sext, regwrite);
                  miscompares++;
               end
            end
            "add_ovf": begin
               vectors++;
               if ({alu_result, overflow} !== {32'h80000000, 1'b1}) begin
                  $display("FAIL ovf_fields got=%h/%b exp=80000000/1", alu_result, overflow);
                  miscompares++;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_midstream_reset();
      logic [136:0] e;
      drive(1'b1, 32'h00411020, 32'd0, 32'd10);
      #2 rst = 1'b1; in_valid = 1'b0;
      #1;
      vectors++;
      if (observed() !== 137'd0) begin
         $display("FAIL midreset_clear got=%h exp=0", observed()); miscompares++;
      end
      vectors++;
      if (rs_addr !== 5'd2) begin
         $display("FAIL midreset_rsaddr got=%h exp=2", rs_addr); miscompares++;
      end
      drive(1'b1, 32'h2021FFFF, 32'd10, 32'd0);
      vectors++;
      if (observed() !== 137'd0) begin
         $display("FAIL midreset_held got=%h exp=0", observed()); miscompares++;
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 32'h2021FFFF, 32'd10, 32'd0);
      vectors++;
      if (observed() !== 137'd0) begin
         $display("FAIL idle_after_reset got=%h exp=0", observed()); miscompares++;
      end
      drive(1'b1, 32'h2021FFFF, 32'd10, 32'd0);
      e = model(1'b1, 32'h2021FFFF, 32'd10, 32'd0);
      vectors++;
      if (observed() !== e) begin
         $display("FAIL first_after_reset got=%h exp=%h", observed(), e); miscompares++;
      end
   endtask

   function automatic logic [31:0] pick_data();
      logic [31:0] edges[5] = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return $urandom();
   endfunction

   task automatic test_random_stream();
      logic [5:0] ops[14] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                              6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
      logic [5:0] fns[19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h3F, 6'h01, 6'h07, 6'h18};
      for (int n = 0; n < 400; n++) begin
         logic [31:0] i, a, b;
         logic        v;
         logic [136:0] e;
         i = $urandom();
         i[31:26] = ($urandom_range(0, 15) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 13)];
         if (i[31:26] == 6'h00) i[5:0] = fns[$urandom_range(0, 18)];
         a = pick_data();
         b = ($urandom_range(0, 4) == 0) ? a : pick_data();
         v = ($urandom_range(0, 7) != 0);
         drive(v, i, a, b);
         e = model(v, i, a, b);
         vectors++;
         if (observed() !== e) begin
            $display("FAIL random[%0d] instr=%h rs=%h rt=%h got=%h exp=%h", n, i, a, b, observed(), e);
            miscompares++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_midstream_reset();
      test_random_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
